// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle unsigned multiply / restoring divide.
// The unit runs one iteration per clock for WIDTH clocks, then spends one
// cycle in DONE where done/wr_en pulse. Results hold until the next completion.
module muldiv_unit #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       dest_reg,
  output logic             busy,
  output logic             done,
  output logic             wr_en,
  output logic [2:0]       wr_reg,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       dest_q, dest_d;
  // hi: multiply accumulator upper half / divide partial remainder (one spare bit)
  // lo: multiplier bits shifting out / dividend bits shifting out, quotient in
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [2:0]       wr_reg_q, wr_reg_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;

  logic             last_iter;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH:0]   hi_nx;
  logic [WIDTH-1:0] lo_nx;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum   = {1'b0, hi_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    if (op_q) begin
      // borrow bit clear -> divisor fits, keep difference and set quotient bit
      if (!div_diff[WIDTH+1]) begin
        hi_nx = div_diff[WIDTH:0];
        lo_nx = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = div_shift;
        lo_nx = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nx = {1'b0, mul_sum[WIDTH:1]};
      lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture on accept, iterate in RUN, latch results on the last iteration
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    dest_d   = dest_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    wr_reg_d = wr_reg_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    if (state_q == S_IDLE && start) begin
      cnt_d  = '0;
      op_d   = op;
      a_d    = a;
      b_d    = b;
      dest_d = dest_reg;
      hi_d   = '0;
      lo_d   = op ? a : b;
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
      hi_d  = hi_nx;
      lo_d  = lo_nx;
      if (last_iter) begin
        res_lo_d = lo_nx;
        res_hi_d = hi_nx[WIDTH-1:0];
        wr_reg_d = dest_q;
        dbz_d    = op_q && (b_q == '0);
      end
    end
  end

  // Registered handshake outputs, derived from the upcoming state
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_RUN) && last_iter;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      dest_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      wr_reg_q <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dest_q   <= dest_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      wr_reg_q <= wr_reg_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign wr_en       = done_q;
  assign wr_reg      = wr_reg_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results with the
// cycle they must appear on; a monitor pops and compares on every done/wr_en.
module tb_muldiv_unit;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset, start, op;
  logic [W-1:0] a, b;
  logic [2:0]   dest_reg;
  logic         busy, done, wr_en, div_by_zero;
  logic [2:0]   wr_reg;
  logic [W-1:0] result_lo, result_hi;

  muldiv_unit #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .dest_reg(dest_reg), .busy(busy), .done(done), .wr_en(wr_en),
    .wr_reg(wr_reg), .result_lo(result_lo), .result_hi(result_hi),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lo;
    int hi;
    int rg;
    int dbz;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match a queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done || wr_en) begin
        chk("wr_en_matches_done", int'(wr_en), int'(done));
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done_pulse required=none (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("result_lo", int'(result_lo), e.lo);
          chk("result_hi", int'(result_hi), e.hi);
          chk("wr_reg", int'(wr_reg), e.rg);
          chk("div_by_zero", int'(div_by_zero), e.dbz);
        end
      end
    end
  end

  // Launch one operation from an idle negedge and queue its expected result
  task automatic issue(input logic o, input int av, input int bv, input int dr,
                       input int elo, input int ehi, input int edbz);
    exp_t e;
    op = o; a = W'(av); b = W'(bv); dest_reg = 3'(dr); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = '1; b = '1; dest_reg = 3'd7; op = ~o;   // captured copies must be used
    e.lo = elo; e.hi = ehi; e.rg = dr; e.dbz = edbz; e.cyc = cyc + 10;
    sbq.push_back(e);
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("busy_timeout", int'(busy), 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0; dest_reg = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_lo", int'(result_lo), 0);
    chk("rst_hi", int'(result_hi), 0);
    chk("rst_wr_reg", int'(wr_reg), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    reset = 1'b1;
    @(negedge clk);

    issue(1'b0, 25, 40, 3, 1000, 0, 0);          wait_idle();
    issue(1'b0, 1023, 1023, 1, 'h001, 'h3FE, 0); wait_idle();
    issue(1'b1, 1000, 7, 5, 142, 6, 0);          wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_lo_idle", int'(result_lo), 142);
    chk("hold_wr_reg_idle", int'(wr_reg), 5);
    issue(1'b1, 3, 9, 2, 0, 3, 0);               wait_idle();

    // Start pulsed mid-operation is dropped; next op launches on the first idle cycle
    issue(1'b1, 1000, 7, 5, 142, 6, 0);
    repeat (2) @(negedge clk);
    op = 1'b0; a = 10'd2; b = 10'd3; dest_reg = 3'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    issue(1'b0, 2, 3, 6, 6, 0, 0);               wait_idle();

    issue(1'b1, 500, 0, 4, 1023, 500, 1);        wait_idle();

    // Abort a 6x7 multiply in its fifth RUN cycle
    op = 1'b0; a = 10'd6; b = 10'd7; dest_reg = 3'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_lo", int'(result_lo), 0);
    chk("abort_hi", int'(result_hi), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    chk("abort_wr_reg", int'(wr_reg), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_stays_idle", int'(busy), 0);

    issue(1'b0, 6, 7, 1, 42, 0, 0);              wait_idle();

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
